// File: rtl/scope_pkg.sv
// Shared acquisition-path definitions: sample width, channel tags, buffer depth rule.
// No logic of its own; used at elaboration by the acquisition buffers.
// No flow control here.
package scope_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Buffer depths must be a power of two so pointers wrap for free, and >= 2
  // so the head and the write slot never alias while a buffer is full.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/chan_demux_buf_if.sv
// Sample stream bundle: tagged interleaved input plus two per-channel valid/ready outputs.
// Pure wiring, no latency.
// Input side has no ready; each output channel is stalled by its own ready.
interface chan_demux_buf_if #(
  parameter int DATA_W = scope_pkg::SAMPLE_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_valid;

  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready;

  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;

  // Source/consumer side: drives samples in, provides readys, sees channel outputs.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  out0_data, out0_valid, out1_data, out1_valid
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output out0_data, out0_valid, out1_data, out1_valid
  );

endinterface

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO with registered head data, valid and level.
// Latency: a push into an empty FIFO is visible on dout/valid after the same edge.
// Backpressure: pop is ignored while valid=0; a push while full is refused unless it pops that cycle.
module sample_fifo import scope_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic              wr_en;
  logic              rd_en;
  logic              load_head;
  logic [DATA_W-1:0] head_nxt;

  // Full comes from the occupancy count; pointers alone cannot tell full from empty.
  assign full   = (level == LVL_W'(DEPTH));
  assign rd_en  = pop && valid;
  assign wr_en  = push && (!full || rd_en);
  assign rd_nxt = rd_ptr + PTR_W'(1);

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Select the next head: the incoming sample when it becomes the only entry,
  // otherwise the entry behind the one being popped. When the last entry pops
  // with nothing arriving, dout simply holds and valid drops.
  always_comb begin
    load_head = 1'b0;
    head_nxt  = din;
    if (wr_en && ((level == '0) || (rd_en && (level == LVL_W'(1))))) begin
      load_head = 1'b1;
      head_nxt  = din;
    end else if (rd_en && (level > LVL_W'(1))) begin
      load_head = 1'b1;
      head_nxt  = mem[rd_nxt];
    end
  end

  // Storage array; contents are don't-care after reset since level gates everything.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head/valid presented to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_nxt;
      level <= level_nxt;
      valid <= (level_nxt != '0);
      if (load_head) dout <= head_nxt;
    end
  end

endmodule

// File: rtl/chan_demux_buf.sv
// Splits a tagged interleaved sample stream into two buffered per-channel streams.
// Latency: a sample reaches an empty channel's output one edge after its push.
// Backpressure: input cannot stall; samples for a full, non-popping channel are dropped and flagged sticky.
module chan_demux_buf import scope_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chan_demux_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0] level0,
  output logic [$clog2(DEPTH):0] level1,
  output logic                   ovf0,
  output logic                   ovf1,
  input  logic                   ovf_clr
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("chan_demux_buf: DEPTH must be a power of two and at least 2");
  end

  logic push0, push1;
  logic pop0, pop1;
  logic full0, full1;
  logic drop0, drop1;

  assign push0 = bus.in_valid && (bus.in_sel == CH0);
  assign push1 = bus.in_valid && (bus.in_sel == CH1);

  // A pop in the same cycle frees the slot, so only a non-popping full channel drops.
  assign pop0  = bus.out0_valid && bus.out0_ready;
  assign pop1  = bus.out1_valid && bus.out1_ready;
  assign drop0 = push0 && full0 && !pop0;
  assign drop1 = push1 && full1 && !pop1;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (bus.out0_ready),
    .din   (bus.in_data),
    .dout  (bus.out0_data),
    .valid (bus.out0_valid),
    .level (level0),
    .full  (full0)
  );

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (bus.out1_ready),
    .din   (bus.in_data),
    .dout  (bus.out1_data),
    .valid (bus.out1_valid),
    .level (level1),
    .full  (full1)
  );

  // Sticky overflow flags; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf0 <= 1'b0;
      ovf1 <= 1'b0;
    end else begin
      if (drop0)        ovf0 <= 1'b1;
      else if (ovf_clr) ovf0 <= 1'b0;
      if (drop1)        ovf1 <= 1'b1;
      else if (ovf_clr) ovf1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_demux_buf.sv
module tb_chan_demux_buf;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ovf_clr;
  logic [3:0] level0, level1;
  logic       ovf0, ovf1;

  chan_demux_buf_if #(.DATA_W(DW)) bus ();

  chan_demux_buf #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .level0  (level0),
    .level1  (level1),
    .ovf0    (ovf0),
    .ovf1    (ovf1),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: one queue per channel plus sticky flags.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_ovf0 = 1'b0;
  logic          m_ovf1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":level0"}, 32'(level0), 32'(q0.size()));
    check({tag, ":valid0"}, 32'(bus.out0_valid), 32'(q0.size() > 0));
    if (q0.size() > 0) check({tag, ":data0"}, 32'(bus.out0_data), 32'(q0[0]));
    check({tag, ":level1"}, 32'(level1), 32'(q1.size()));
    check({tag, ":valid1"}, 32'(bus.out1_valid), 32'(q1.size() > 0));
    if (q1.size() > 0) check({tag, ":data1"}, 32'(bus.out1_data), 32'(q1[0]));
    check({tag, ":ovf0"}, 32'(ovf0), 32'(m_ovf0));
    check({tag, ":ovf1"}, 32'(ovf1), 32'(m_ovf1));
  endtask

  // One clock: drive inputs (called just after a falling edge), let the edge
  // happen, apply the queue rules, then compare on the next falling edge.
  task automatic step(input string tag, input logic v, input logic s, input logic [DW-1:0] d,
                      input logic r0, input logic r1, input logic clr);
    logic ev0, ev1;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    ovf_clr        = clr;
    @(posedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (r0 && q0.size() > 0) void'(q0.pop_front());
    if (r1 && q1.size() > 0) void'(q1.pop_front());
    if (v) begin
      if (!s) begin
        if (q0.size() < DEPTH) q0.push_back(d); else ev0 = 1'b1;
      end else begin
        if (q1.size() < DEPTH) q1.push_back(d); else ev1 = 1'b1;
      end
    end
    m_ovf0 = ev0 ? 1'b1 : (clr ? 1'b0 : m_ovf0);
    m_ovf1 = ev1 ? 1'b1 : (clr ? 1'b0 : m_ovf1);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n          = 1'b0;
    ovf_clr        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    // Reset values, before and after an edge inside reset.
    #3;
    check("rst_data0", 32'(bus.out0_data), 32'h0);
    check("rst_data1", 32'(bus.out1_data), 32'h0);
    check_all("rst_pre_edge");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_post_edge");
    rst_n = 1'b1;

    // Routing and latency.
    step("route_a", 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0);
    check("route_a_head0", 32'(bus.out0_data), 32'h11);
    step("route_b", 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    check("route_b_head1", 32'(bus.out1_data), 32'h22);
    step("route_c", 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    check("route_c_head0", 32'(bus.out0_data), 32'h33);
    step("route_idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Fill ch0 past depth with no pops.
    for (int i = 0; i < 9; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
    check("fill_level0", 32'(level0), 32'd8);
    check("fill_ovf0", 32'(ovf0), 32'd1);
    check("fill_ovf1", 32'(ovf1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(bus.out0_data), 32'(i));
      step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    end
    check("drained_valid0", 32'(bus.out0_valid), 32'd0);
    step("clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_ovf0", 32'(ovf0), 32'd0);

    // Full with simultaneous pop accepts the push.
    for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step("full_pop", 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("full_pop_level0", 32'(level0), 32'd8);
    check("full_pop_ovf0", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain2_empty", 32'(level0), 32'd0);

    // Backpressure hold on ch1 while ch0 keeps flowing.
    step("bp_load", 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("bp_hold", 1'b1, 1'b0, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
      check("bp_data1", 32'(bus.out1_data), 32'h5A);
      check("bp_valid1", 32'(bus.out1_valid), 32'd1);
    end
    step("bp_release", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Clear versus set.
    for (int i = 0; i < 9; i++) step("fill3", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
    check("cs_set", 32'(ovf0), 32'd1);
    step("cs_both", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b1);
    check("cs_set_wins", 32'(ovf0), 32'd1);
    step("cs_clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("cs_cleared", 32'(ovf0), 32'd0);
    while (q0.size() > 0) step("drain3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset with three entries in each channel.
    for (int i = 0; i < 3; i++) begin
      step("pre_rst0", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      step("pre_rst1", 1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    end
    check("pre_rst_level0", 32'(level0), 32'd3);
    check("pre_rst_level1", 32'(level1), 32'd3);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
    check_all("async_rst");
    check("async_rst_data0", 32'(bus.out0_data), 32'h0);
    check("async_rst_data1", 32'(bus.out1_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    check("post_rst_data1", 32'(bus.out1_data), 32'h7E);
    check("post_rst_level1", 32'(level1), 32'd1);
    check("post_rst_valid0", 32'(bus.out0_valid), 32'd0);
    while (q1.size() > 0) step("drain4", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           8'($urandom),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
